// File: rtl/rv32i_instr_enc.sv
// RV32I instruction encoder: packs field tuples into 32-bit words and buffers
// them in a small FIFO, emitting each word with a running index.
// Optional build macro IMM_RANGE_CHECK_EN rejects immediates that do not fit
// the selected format instead of silently truncating them.
//
// Illegal formats are consumed without producing a word. They raise a
// one-cycle err_o and bump a saturating error counter.
module rv32i_instr_enc #(
   parameter int FIFO_DEPTH = 2,
   parameter int IDX_W      = 10
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             flush_i,
   input  logic             in_valid_i,
   output logic             in_ready_o,
   input  logic [2:0]       fmt_i,
   input  logic [6:0]       opcode_i,
   input  logic [4:0]       rd_i,
   input  logic [4:0]       rs1_i,
   input  logic [4:0]       rs2_i,
   input  logic [2:0]       funct3_i,
   input  logic [6:0]       funct7_i,
   input  logic [31:0]      imm_i,
   output logic             out_valid_o,
   input  logic             out_ready_i,
   output logic [31:0]      instr_o,
   output logic [IDX_W-1:0] idx_o,
   output logic             err_o,
   output logic [7:0]       err_cnt_o
);

   localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
   localparam int CNT_W = PTR_W + 1;

   localparam logic [2:0] FMT_R = 3'd0;
   localparam logic [2:0] FMT_I = 3'd1;
   localparam logic [2:0] FMT_S = 3'd2;
   localparam logic [2:0] FMT_B = 3'd3;
   localparam logic [2:0] FMT_U = 3'd4;
   localparam logic [2:0] FMT_J = 3'd5;

   logic [31:0]      mem_q [FIFO_DEPTH];
   logic [31:0]      mem_d [FIFO_DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic [IDX_W-1:0] idx_q, idx_d;
   logic             err_q, err_d;
   logic [7:0]       err_cnt_q, err_cnt_d;

   logic [31:0]      enc_word;
   logic             fmt_ok;
   logic             imm_bad;
   logic             accept, reject, push, pop;

   // Place each field at its standard RV32I bit position for the chosen format
   always_comb begin
      enc_word = '0;
      fmt_ok   = 1'b1;
      case (fmt_i)
         FMT_R: enc_word = {funct7_i, rs2_i, rs1_i, funct3_i, rd_i, opcode_i};
         FMT_I: enc_word = {imm_i[11:0], rs1_i, funct3_i, rd_i, opcode_i};
         FMT_S: enc_word = {imm_i[11:5], rs2_i, rs1_i, funct3_i, imm_i[4:0], opcode_i};
         FMT_B: enc_word = {imm_i[12], imm_i[10:5], rs2_i, rs1_i, funct3_i,
                            imm_i[4:1], imm_i[11], opcode_i};
         FMT_U: enc_word = {imm_i[31:12], rd_i, opcode_i};
         FMT_J: enc_word = {imm_i[20], imm_i[10:1], imm_i[11], imm_i[19:12], rd_i, opcode_i};
         default: fmt_ok = 1'b0;
      endcase
   end

`ifdef IMM_RANGE_CHECK_EN
   // A signed value fits when all bits from the sign position upward agree
   always_comb begin
      imm_bad = 1'b0;
      case (fmt_i)
         FMT_I, FMT_S: imm_bad = !((&imm_i[31:11]) || !(|imm_i[31:11]));
         FMT_B:        imm_bad = !((&imm_i[31:12]) || !(|imm_i[31:12])) || imm_i[0];
         FMT_J:        imm_bad = !((&imm_i[31:20]) || !(|imm_i[31:20])) || imm_i[0];
         FMT_U:        imm_bad = |imm_i[11:0];
         default:      imm_bad = 1'b0;
      endcase
   end
`else
   assign imm_bad = 1'b0;
`endif

   // Ready is held low during reset; only the registered count frees a slot
   assign in_ready_o  = rst_ni && (count_q < CNT_W'(FIFO_DEPTH));
   assign accept      = in_valid_i && in_ready_o;
   assign reject      = accept && (!fmt_ok || imm_bad);
   assign push        = accept && fmt_ok && !imm_bad && !flush_i;
   assign out_valid_o = (count_q != '0);
   assign pop         = out_valid_o && out_ready_i && !flush_i;

   assign instr_o   = out_valid_o ? mem_q[rd_ptr_q] : 32'h0;
   assign idx_o     = idx_q;
   assign err_o     = err_q;
   assign err_cnt_o = err_cnt_q;

   // Next-state for FIFO storage, pointers, index and error bookkeeping
   always_comb begin
      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      idx_d     = idx_q;
      err_d     = reject;
      err_cnt_d = err_cnt_q;
      if (reject && (err_cnt_q != 8'hFF)) begin
         err_cnt_d = err_cnt_q + 8'd1;
      end
      if (flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
         idx_d    = '0;
      end else begin
         if (push) begin
            mem_d[wr_ptr_q] = enc_word;
            wr_ptr_d        = wr_ptr_q + 1'b1;
         end
         if (pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
            idx_d    = idx_q + 1'b1;
         end
         case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
         endcase
      end
   end

   // State registers; reset drops any buffered words
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         for (int i = 0; i < FIFO_DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         idx_q     <= '0;
         err_q     <= 1'b0;
         err_cnt_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         idx_q     <= idx_d;
         err_q     <= err_d;
         err_cnt_q <= err_cnt_d;
      end
   end

endmodule

// File: tb/tb_rv32i_instr_enc.sv
// Directed bench for rv32i_instr_enc with hand-computed instruction words.
module tb_rv32i_instr_enc;

   logic        clk_i = 1'b0;
   logic        rst_ni = 1'b0;
   logic        flush_i = 1'b0;
   logic        in_valid_i = 1'b0;
   logic        in_ready_o;
   logic [2:0]  fmt_i = '0;
   logic [6:0]  opcode_i = '0;
   logic [4:0]  rd_i = '0;
   logic [4:0]  rs1_i = '0;
   logic [4:0]  rs2_i = '0;
   logic [2:0]  funct3_i = '0;
   logic [6:0]  funct7_i = '0;
   logic [31:0] imm_i = '0;
   logic        out_valid_o;
   logic        out_ready_i = 1'b0;
   logic [31:0] instr_o;
   logic [9:0]  idx_o;
   logic        err_o;
   logic [7:0]  err_cnt_o;

   int checks = 0;
   int errors = 0;
   int exp_idx = 0;
   int exp_errs = 0;

   rv32i_instr_enc #(.FIFO_DEPTH(2), .IDX_W(10)) dut (
      .clk_i(clk_i), .rst_ni(rst_ni), .flush_i(flush_i),
      .in_valid_i(in_valid_i), .in_ready_o(in_ready_o),
      .fmt_i(fmt_i), .opcode_i(opcode_i), .rd_i(rd_i), .rs1_i(rs1_i),
      .rs2_i(rs2_i), .funct3_i(funct3_i), .funct7_i(funct7_i), .imm_i(imm_i),
      .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
      .instr_o(instr_o), .idx_o(idx_o), .err_o(err_o), .err_cnt_o(err_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk_i);
      #1;
   endtask

   task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                        input logic [6:0] f7, input logic [31:0] imm);
      fmt_i = f; opcode_i = op; rd_i = rd; rs1_i = r1; rs2_i = r2;
      funct3_i = f3; funct7_i = f7; imm_i = imm;
      in_valid_i = 1'b1;
   endtask

   task automatic send(input logic [2:0] f, input logic [6:0] op, input logic [4:0] rd,
                       input logic [4:0] r1, input logic [4:0] r2, input logic [2:0] f3,
                       input logic [6:0] f7, input logic [31:0] imm);
      drive(f, op, rd, r1, r2, f3, f7, imm);
      step();
      in_valid_i = 1'b0;
   endtask

   task automatic pop_one();
      out_ready_i = 1'b1;
      step();
      out_ready_i = 1'b0;
      exp_idx++;
   endtask

   task automatic expect_word(input string tag, input logic [31:0] w);
      chk({tag, "_valid"}, {31'd0, out_valid_o}, 32'd1);
      chk({tag, "_instr"}, instr_o, w);
      chk({tag, "_idx"}, {22'd0, idx_o}, 32'(exp_idx));
   endtask

   initial begin
      #12;
      chk("rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("rst_instr", instr_o, 32'h0);
      chk("rst_idx", {22'd0, idx_o}, 32'd0);
      chk("rst_err", {31'd0, err_o}, 32'd0);
      chk("rst_errcnt", {24'd0, err_cnt_o}, 32'd0);
      chk("rst_ready", {31'd0, in_ready_o}, 32'd0);
      #1 rst_ni = 1'b1;
      step();
      chk("post_rst_ready", {31'd0, in_ready_o}, 32'd1);

      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      expect_word("enc_i", 32'h00500093);
      pop_one();
      chk("pop_i_valid", {31'd0, out_valid_o}, 32'd0);
      chk("pop_i_idx", {22'd0, idx_o}, 32'd1);

      send(3'd2, 7'h23, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd8);
      expect_word("enc_s", 32'h0020A423);
      pop_one();
      send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'hFFFF_FFFC);
      expect_word("enc_b", 32'hFE000EE3);
      pop_one();
      send(3'd5, 7'h6F, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      expect_word("enc_j", 32'h001000EF);
      pop_one();
      send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
      expect_word("enc_u", 32'h123452B7);
      pop_one();
      send(3'd0, 7'h33, 5'd3, 5'd1, 5'd2, 3'd0, 7'h20, 32'hFFFF_FFFF);
      expect_word("enc_r_sub", 32'h402081B3);
      pop_one();

`ifdef IMM_RANGE_CHECK_EN
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      exp_errs++;
      chk("rng_i_err", {31'd0, err_o}, 32'd1);
      chk("rng_i_valid", {31'd0, out_valid_o}, 32'd0);
      send(3'd3, 7'h63, 5'd0, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      exp_errs++;
      chk("rng_b_err", {31'd0, err_o}, 32'd1);
      chk("rng_b_cnt", {24'd0, err_cnt_o}, 32'(exp_errs));
`else
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2048);
      expect_word("trunc_i", 32'h80000093);
      chk("trunc_no_err", {31'd0, err_o}, 32'd0);
      pop_one();
`endif

      send(3'd7, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd0);
      exp_errs++;
      chk("illegal_err", {31'd0, err_o}, 32'd1);
      chk("illegal_cnt", {24'd0, err_cnt_o}, 32'(exp_errs));
      chk("illegal_no_out", {31'd0, out_valid_o}, 32'd0);
      step();
      chk("illegal_pulse_end", {31'd0, err_o}, 32'd0);

      // backpressure: two accepts fill the buffer, third waits
      drive(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      step();
      chk("bp_ready1", {31'd0, in_ready_o}, 32'd1);
      expect_word("bp_a", 32'h00100093);
      drive(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
      step();
      chk("bp_ready2", {31'd0, in_ready_o}, 32'd0);
      drive(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      step();
      chk("bp_stall_ready", {31'd0, in_ready_o}, 32'd0);
      expect_word("bp_hold_a", 32'h00100093);
      out_ready_i = 1'b1;
      step();
      exp_idx++;
      expect_word("bp_b", 32'h00200113);
      chk("bp_ready3", {31'd0, in_ready_o}, 32'd1);
      step();
      exp_idx++;
      in_valid_i = 1'b0;
      expect_word("bp_c", 32'h00300193);
      step();
      exp_idx++;
      out_ready_i = 1'b0;
      chk("bp_drained", {31'd0, out_valid_o}, 32'd0);
      chk("bp_idx", {22'd0, idx_o}, 32'(exp_idx));

      // flush with two words buffered and a concurrent push
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
      drive(3'd1, 7'h13, 5'd3, 5'd0, 5'd0, 3'd0, 7'd0, 32'd3);
      flush_i = 1'b1;
      step();
      flush_i = 1'b0;
      in_valid_i = 1'b0;
      exp_idx = 0;
      chk("flush_valid", {31'd0, out_valid_o}, 32'd0);
      chk("flush_idx", {22'd0, idx_o}, 32'd0);
      chk("flush_keep_cnt", {24'd0, err_cnt_o}, 32'(exp_errs));
      step();
      chk("flush_push_dropped", {31'd0, out_valid_o}, 32'd0);
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5);
      expect_word("flush_next", 32'h00500093);
      pop_one();
      chk("flush_pop_idx", {22'd0, idx_o}, 32'd1);

      // reset pulse mid-stream
      send(3'd1, 7'h13, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd1);
      send(3'd1, 7'h13, 5'd2, 5'd0, 5'd0, 3'd0, 7'd0, 32'd2);
      rst_ni = 1'b0;
      #2;
      chk("mid_rst_valid", {31'd0, out_valid_o}, 32'd0);
      chk("mid_rst_instr", instr_o, 32'h0);
      chk("mid_rst_idx", {22'd0, idx_o}, 32'd0);
      chk("mid_rst_cnt", {24'd0, err_cnt_o}, 32'd0);
      chk("mid_rst_ready", {31'd0, in_ready_o}, 32'd0);
      #3 rst_ni = 1'b1;
      exp_idx = 0;
      step();
      send(3'd4, 7'h37, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h1234_5000);
      expect_word("rst_next_u", 32'h123452B7);
      pop_one();
      chk("rst_next_idx", {22'd0, idx_o}, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      #50000;
      errors++;
      $display("FAIL timeout observed=running expected=finished");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $fatal(1, "timeout");
   end

endmodule
